// File: rtl/fp16_pkg.sv
// fp16_pkg: shared widths, field positions, exception codes, the FSM state
// encoding and operand-decode helpers for the fp16 adder front-end.
package fp16_pkg;

  localparam int EXP_W     = 5;
  localparam int FRAC_W    = 10;
  localparam int EXT_MAN_W = 16;
  localparam int EXP_OUT_W = 6;

  localparam logic [EXP_W-1:0] EXP_MAX = 5'd31;

  // Extended mantissa layout: [15] headroom, [14] hidden, [13:4] fraction,
  // [3] guard, [2] round, [1] sticky, [0] zero.
  localparam int HIDDEN_BIT = 14;
  localparam int GUARD_BIT  = 3;
  localparam int STICKY_BIT = 1;

  typedef enum logic [1:0] {
    EXC_NONE = 2'b00,
    EXC_INF  = 2'b01,
    EXC_NAN  = 2'b10,
    EXC_RSVD = 2'b11
  } exc_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_UNPACK = 2'b01,
    ST_SHIFT  = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

  function automatic logic [EXP_W-1:0] exp_field(input logic [15:0] op);
    return op[FRAC_W+EXP_W-1:FRAC_W];
  endfunction

  function automatic logic [FRAC_W-1:0] frac_field(input logic [15:0] op);
    return op[FRAC_W-1:0];
  endfunction

  // Denormals (exp field 0) behave as exponent 1.
  function automatic logic [EXP_W-1:0] eff_exp(input logic [15:0] op);
    logic [EXP_W-1:0] e;
    e = exp_field(op);
    if (e == 5'd0) begin
      return 5'd1;
    end else begin
      return e;
    end
  endfunction

  function automatic logic [EXT_MAN_W-1:0] ext_mantissa(input logic [15:0] op);
    logic [EXT_MAN_W-1:0] m;
    m = 16'h0000;
    m[HIDDEN_BIT] = (exp_field(op) != 5'd0);
    m[GUARD_BIT+FRAC_W:GUARD_BIT+1] = frac_field(op);
    return m;
  endfunction

  function automatic logic is_special(input logic [15:0] op);
    return (exp_field(op) == EXP_MAX);
  endfunction

  function automatic logic is_nan(input logic [15:0] op);
    return (exp_field(op) == EXP_MAX) && (frac_field(op) != 10'd0);
  endfunction

endpackage

// File: rtl/sticky_shift.sv
// sticky_shift: combinational right shift of an extended mantissa by
// 0..SHIFT_STEP positions. Every bit that falls below bit[2] (shifted out or
// landing in bits [1:0]) is ORed, together with the old bit[1], into bit[1];
// bit[0] is always 0.
//   man    in  16  extended mantissa to shift
//   amt    in  4   shift amount (values above SHIFT_STEP are clamped)
//   result out 16  shifted mantissa with sticky collected in bit[1]
module sticky_shift
  import fp16_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic [EXT_MAN_W-1:0] man,
  input  logic [3:0]           amt,
  output logic [EXT_MAN_W-1:0] result
);

  logic [3:0]             amt_eff;
  logic [2*EXT_MAN_W-2:0] wide;
  logic                   sticky;

  // Shift through a wide window so lost bits stay visible for the sticky OR.
  always_comb begin
    if (int'(amt) > SHIFT_STEP) begin
      amt_eff = 4'(SHIFT_STEP);
    end else begin
      amt_eff = amt;
    end
    wide   = {man, {(EXT_MAN_W-1){1'b0}}} >> amt_eff;
    // wide[16:0] holds everything that now sits below mantissa bit[2].
    sticky = (|wide[EXT_MAN_W:0]) | man[STICKY_BIT];
    result = {wide[2*EXT_MAN_W-2:EXT_MAN_W+1], sticky, 1'b0};
  end

endmodule

// File: rtl/fp16_operand_align.sv
// fp16_operand_align: front-end of the fp16 adder. Captures two packed
// half-precision operands, unpacks them into extended mantissas, orders them
// by effective exponent and right-aligns the smaller mantissa with sticky
// collection, SHIFT_STEP positions per cycle.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake (in_ready = state is IDLE)
//   in_a, in_b            packed fp16 operands
//   out_valid/out_ready   result handshake
//   out_man_big/_small    extended mantissas (big unshifted, small aligned)
//   out_exp               common exponent, zero-extended
//   out_sign_big/_small   operand signs, out_swap = 1 when B is big
//   exception             00 normal, 01 infinity, 10 NaN
module fp16_operand_align
  import fp16_pkg::*;
#(
  parameter int SHIFT_STEP = 1,
  parameter int MAX_SHIFT  = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_a,
  input  logic [15:0]          in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXT_MAN_W-1:0] out_man_big,
  output logic [EXT_MAN_W-1:0] out_man_small,
  output logic [EXP_OUT_W-1:0] out_exp,
  output logic                 out_sign_big,
  output logic                 out_sign_small,
  output logic                 out_swap,
  output logic [1:0]           exception
);

  state_e               state_r, next_state_s;
  logic [15:0]          a_r, b_r;
  logic [EXT_MAN_W-1:0] man_big_r, man_small_r, shifted_s;
  logic [EXP_OUT_W-1:0] exp_r;
  logic                 sign_big_r, sign_small_r, swap_r, valid_r, valid_next_s;
  logic [1:0]           exc_r;
  logic [4:0]           rem_r;
  logic [3:0]           step_s;
  logic [EXP_W-1:0]     ea_s, eb_s, diff_s;
  logic [4:0]           dist_s;
  logic                 a_big_s, special_s, nan_s;

  // Decode of the captured operands, consumed in UNPACK.
  always_comb begin
    ea_s    = eff_exp(a_r);
    eb_s    = eff_exp(b_r);
    a_big_s = (ea_s >= eb_s);  // ties keep A as the big operand
    if (a_big_s) begin
      diff_s = ea_s - eb_s;
    end else begin
      diff_s = eb_s - ea_s;
    end
    if (int'(diff_s) > MAX_SHIFT) begin
      dist_s = 5'(MAX_SHIFT);
    end else begin
      dist_s = diff_s;
    end
    special_s = is_special(a_r) | is_special(b_r);
    nan_s     = is_nan(a_r) | is_nan(b_r);
  end

  // Per-cycle shift amount: full step, or whatever distance is left.
  always_comb begin
    if (int'(rem_r) < SHIFT_STEP) begin
      step_s = rem_r[3:0];
    end else begin
      step_s = 4'(SHIFT_STEP);
    end
  end

  sticky_shift #(
    .SHIFT_STEP(SHIFT_STEP)
  ) u_sticky_shift (
    .man    (man_small_r),
    .amt    (step_s),
    .result (shifted_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          next_state_s = ST_UNPACK;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_UNPACK: begin
        if (special_s) begin
          next_state_s = ST_DONE;
        end else if (dist_s != 5'd0) begin
          next_state_s = ST_SHIFT;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      ST_SHIFT: begin
        if ({1'b0, step_s} == rem_r) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: input handshake and the next value of out_valid.
  always_comb begin
    if (state_r == ST_IDLE) begin
      in_ready = 1'b1;
    end else begin
      in_ready = 1'b0;
    end
    valid_next_s = (next_state_s == ST_DONE);
  end

  // Registered out_valid, high exactly while the FSM sits in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_next_s;
    end
  end

  // Datapath: operand capture, unpack/ordering, and iterative alignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r          <= 16'h0000;
      b_r          <= 16'h0000;
      man_big_r    <= 16'h0000;
      man_small_r  <= 16'h0000;
      exp_r        <= 6'd0;
      sign_big_r   <= 1'b0;
      sign_small_r <= 1'b0;
      swap_r       <= 1'b0;
      exc_r        <= EXC_NONE;
      rem_r        <= 5'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r <= in_a;
            b_r <= in_b;
          end
        end
        ST_UNPACK: begin
          if (a_big_s) begin
            man_big_r    <= ext_mantissa(a_r);
            man_small_r  <= ext_mantissa(b_r);
            exp_r        <= {1'b0, ea_s};
            sign_big_r   <= a_r[15];
            sign_small_r <= b_r[15];
            swap_r       <= 1'b0;
          end else begin
            man_big_r    <= ext_mantissa(b_r);
            man_small_r  <= ext_mantissa(a_r);
            exp_r        <= {1'b0, eb_s};
            sign_big_r   <= b_r[15];
            sign_small_r <= a_r[15];
            swap_r       <= 1'b1;
          end
          // NaN outranks infinity when both kinds are present.
          if (nan_s) begin
            exc_r <= EXC_NAN;
          end else if (special_s) begin
            exc_r <= EXC_INF;
          end else begin
            exc_r <= EXC_NONE;
          end
          rem_r <= dist_s;
        end
        ST_SHIFT: begin
          man_small_r <= shifted_s;
          rem_r       <= rem_r - {1'b0, step_s};
        end
        ST_DONE: begin
          // Outputs hold until the result is taken.
        end
        default: begin
          rem_r <= 5'd0;
        end
      endcase
    end
  end

  assign out_valid      = valid_r;
  assign out_man_big    = man_big_r;
  assign out_man_small  = man_small_r;
  assign out_exp        = exp_r;
  assign out_sign_big   = sign_big_r;
  assign out_sign_small = sign_small_r;
  assign out_swap       = swap_r;
  assign exception      = exc_r;

endmodule

// File: tb/tb_fp16_operand_align.sv
// Directed, table-driven bench for fp16_operand_align. Two instances share the
// stimulus: one with SHIFT_STEP=1 and one with SHIFT_STEP=4, so alignment
// results and latencies are checked for both step sizes.
module tb_fp16_operand_align;

  logic        clk, rst_n, in_valid, out_ready;
  logic [15:0] in_a, in_b;

  logic        in_ready_1, out_valid_1, sign_big_1, sign_small_1, swap_1;
  logic [15:0] man_big_1, man_small_1;
  logic [5:0]  exp_1;
  logic [1:0]  exc_1;

  logic        in_ready_4, out_valid_4, sign_big_4, sign_small_4, swap_4;
  logic [15:0] man_big_4, man_small_4;
  logic [5:0]  exp_4;
  logic [1:0]  exc_4;

  int tests = 0;
  int fails = 0;

  fp16_operand_align #(.SHIFT_STEP(1), .MAX_SHIFT(15)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_1),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid_1), .out_ready(out_ready),
    .out_man_big(man_big_1), .out_man_small(man_small_1), .out_exp(exp_1),
    .out_sign_big(sign_big_1), .out_sign_small(sign_small_1),
    .out_swap(swap_1), .exception(exc_1)
  );

  fp16_operand_align #(.SHIFT_STEP(4), .MAX_SHIFT(15)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_4),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid_4), .out_ready(out_ready),
    .out_man_big(man_big_4), .out_man_small(man_small_4), .out_exp(exp_4),
    .out_sign_big(sign_big_4), .out_sign_small(sign_small_4),
    .out_swap(swap_4), .exception(exc_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] man_big;
    logic [15:0] man_small;
    logic [5:0]  exp;
    logic        sign_big;
    logic        sign_small;
    logic        swap;
    logic [1:0]  exc;
    int          lat1;
    int          lat4;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  // Present a pair, then count edges until each instance raises out_valid.
  task automatic run_pair(input logic [15:0] a, input logic [15:0] b,
                          output int lat1, output int lat4);
    @(negedge clk);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = 16'hDEAD;  // must not affect the captured operands
    in_b = 16'hBEEF;
    lat1 = -1;
    lat4 = -1;
    for (int n = 1; n <= 40 && (lat1 < 0 || lat4 < 0); n++) begin
      @(posedge clk);
      #1;
      if (lat1 < 0 && out_valid_1) lat1 = n;
      if (lat4 < 0 && out_valid_4) lat4 = n;
    end
  endtask

  task automatic drain(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, " valid_drop"}, 32'({out_valid_1, out_valid_4}), 32'd0);
    check({name, " ready_back"}, 32'({in_ready_1, in_ready_4}), 32'd3);
  endtask

  task automatic check_vec(input int idx, input vec_t v, input int lat1, input int lat4);
    string p;
    p = $sformatf("v%0d", idx);
    check({p, " man_big1"},   32'(man_big_1),    32'(v.man_big));
    check({p, " man_small1"}, 32'(man_small_1),  32'(v.man_small));
    check({p, " exp1"},       32'(exp_1),        32'(v.exp));
    check({p, " signs1"},     32'({sign_big_1, sign_small_1}), 32'({v.sign_big, v.sign_small}));
    check({p, " swap1"},      32'(swap_1),       32'(v.swap));
    check({p, " exc1"},       32'(exc_1),        32'(v.exc));
    check({p, " lat1"},       32'(lat1),         32'(v.lat1));
    check({p, " man_big4"},   32'(man_big_4),    32'(v.man_big));
    check({p, " man_small4"}, 32'(man_small_4),  32'(v.man_small));
    check({p, " exp4"},       32'(exp_4),        32'(v.exp));
    check({p, " signs4"},     32'({sign_big_4, sign_small_4}), 32'({v.sign_big, v.sign_small}));
    check({p, " swap4"},      32'(swap_4),       32'(v.swap));
    check({p, " exc4"},       32'(exc_4),        32'(v.exc));
    check({p, " lat4"},       32'(lat4),         32'(v.lat4));
  endtask

  task automatic check_zero(input string name);
    check({name, " valid"},  32'({out_valid_1, out_valid_4}), 32'd0);
    check({name, " ready"},  32'({in_ready_1, in_ready_4}), 32'd3);
    check({name, " mans"},   {man_big_1, man_small_1}, 32'd0);
    check({name, " mans4"},  {man_big_4, man_small_4}, 32'd0);
    check({name, " misc"},   32'({exp_1, sign_big_1, sign_small_1, swap_1, exc_1,
                                  exp_4, sign_big_4, sign_small_4, swap_4, exc_4}), 32'd0);
  endtask

  initial begin
    int l1, l4;

    //           a        b        big      small    exp sb ss sw exc  l1  l4
    vecs[0]  = '{16'h4000, 16'h3C00, 16'h4000, 16'h2000, 6'd16, 1'b0, 1'b0, 1'b0, 2'b00,  2, 2};
    vecs[1]  = '{16'h3C00, 16'h4000, 16'h4000, 16'h2000, 6'd16, 1'b0, 1'b0, 1'b1, 2'b00,  2, 2};
    vecs[2]  = '{16'h3C00, 16'h3C00, 16'h4000, 16'h4000, 6'd15, 1'b0, 1'b0, 1'b0, 2'b00,  1, 1};
    vecs[3]  = '{16'h3C00, 16'h0001, 16'h4000, 16'h0002, 6'd15, 1'b0, 1'b0, 1'b0, 2'b00, 15, 5};
    vecs[4]  = '{16'h7C00, 16'h3C00, 16'h4000, 16'h4000, 6'd31, 1'b0, 1'b0, 1'b0, 2'b01,  1, 1};
    vecs[5]  = '{16'h7E00, 16'h7C00, 16'h6000, 16'h4000, 6'd31, 1'b0, 1'b0, 1'b0, 2'b10,  1, 1};
    vecs[6]  = '{16'hC000, 16'h3C00, 16'h4000, 16'h2000, 6'd16, 1'b1, 1'b0, 1'b0, 2'b00,  2, 2};
    vecs[7]  = '{16'h7800, 16'h0400, 16'h4000, 16'h0002, 6'd30, 1'b0, 1'b0, 1'b0, 2'b00, 16, 5};
    vecs[8]  = '{16'h4400, 16'h3FFF, 16'h4000, 16'h1FFC, 6'd17, 1'b0, 1'b0, 1'b0, 2'b00,  3, 2};
    vecs[9]  = '{16'h4C00, 16'h3FFF, 16'h4000, 16'h07FE, 6'd19, 1'b0, 1'b0, 1'b0, 2'b00,  5, 2};
    vecs[10] = '{16'h0003, 16'h0001, 16'h0030, 16'h0010, 6'd1,  1'b0, 1'b0, 1'b0, 2'b00,  1, 1};
    vecs[11] = '{16'hBC00, 16'h4000, 16'h4000, 16'h2000, 6'd16, 1'b0, 1'b1, 1'b1, 2'b00,  2, 2};
    vecs[12] = '{16'h3C00, 16'hFC00, 16'h4000, 16'h4000, 6'd31, 1'b1, 1'b0, 1'b1, 2'b01,  1, 1};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_a = 16'h0000;
    in_b = 16'h0000;
    #23;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_pair(vecs[i].a, vecs[i].b, l1, l4);
      check_vec(i, vecs[i], l1, l4);
      drain($sformatf("v%0d", i));
    end

    // Backpressure: result held, new requests ignored while in DONE.
    run_pair(16'h4000, 16'h3C00, l1, l4);
    check("bp lat1", 32'(l1), 32'd2);
    @(negedge clk);
    in_valid = 1'b1;
    in_a = 16'h7E00;
    in_b = 16'h0001;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp%0d valid", c), 32'({out_valid_1, out_valid_4}), 32'd3);
      check($sformatf("bp%0d ready", c), 32'({in_ready_1, in_ready_4}), 32'd0);
      check($sformatf("bp%0d mans", c), {man_big_1, man_small_1}, 32'h4000_2000);
      check($sformatf("bp%0d exp_exc", c), 32'({exp_1, exc_1, swap_1}), 32'({6'd16, 2'b00, 1'b0}));
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain("bp");
    @(posedge clk);
    #1;
    check("bp idle_hold", 32'({in_ready_1, out_valid_1}), 32'b10);

    // Reset in the middle of a long alignment.
    @(negedge clk);
    in_a = 16'h3C00;
    in_b = 16'h0001;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid busy", 32'({in_ready_1, in_ready_4, out_valid_1, out_valid_4}), 32'd0);
    rst_n = 1'b0;
    #2;
    check_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_pair(vecs[0].a, vecs[0].b, l1, l4);
    check_vec(100, vecs[0], l1, l4);
    drain("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
